booth_seq_mult: RTL
===================

# booth_seq_mult

Sequential radix-4 Booth multiplier for the CNN MAC path: multiplies an unsigned 8-bit activation by a signed 8-bit weight using a single `boothEncoding` partial-product slice. The slice is time-shared over the four Booth digits of the weight, one digit per cycle. Operands arrive on a valid/ready handshake from the feature-map fetch logic. The 16-bit signed product is returned on a valid/ready handshake to the accumulator stage.

## Interface
Parameters:
- SKIP_ZERO, default 0 — 1 enables early termination when all remaining Booth digits encode zero.

Ports:
- clk  input  1  — single clock; all state updates on its rising edge.
- rst_n  input  1  — reset, synchronous and active-low.
- in_valid  input  1  — operand pair valid.
- in_ready  output  1  — block can accept operands.
- in_a  input  8  — multiplicand, unsigned (activation).
- in_b  input  8  — multiplier, signed two's complement (weight).
- out_valid  output  1  — product valid.
- out_ready  input  1  — downstream accepts product.
- out_p  output  16  — product, signed two's complement.

## Operation
- Instantiates one `boothEncoding`:
  - a input = {1'b0, a_reg}, zero-extended to 9 bits, so that ±2a fits the 10-bit pp.
  - encoding input = digit triplet for the current index.
- Digit i (i = 0..3) = {b_reg[2i+1], b_reg[2i], b_reg[2i-1]}, with b_reg[-1] = 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch a_reg = in_a, b_reg = in_b; acc = 0; idx = 0; go to CALC.
- CALC, each cycle:
  - acc = acc + (sign-extend pp to 16 bits << 2·idx), modulo 2^16; idx = idx + 1.
  - After the idx = 3 update, go to DONE.
  - If SKIP_ZERO = 1 and b_reg[7:2·idx+1] are all equal after adding digit idx, go to DONE immediately. The remaining digits are all 000/111 and therefore zero.
- DONE:
  - out_valid = 1, out_p = acc.
  - On out_ready = 1, go to IDLE.
- in_ready = 1 only in IDLE. in_valid in CALC/DONE is ignored; no operand is latched.
- Arithmetic: intermediate sums wrap modulo 2^16. The final result is exact because the range is −32640 … 32385.
- Output stability: out_p and out_valid hold unchanged while out_valid = 1 and out_ready = 0.
- Registers: a_reg, b_reg, acc[15:0], idx[1:0], state.

## Timing
- Reset (rst_n low at a clock edge):
  - state = IDLE, acc = 0, idx = 0, out_valid = 0, out_p = 0.
  - in_ready is forced to 0 while rst_n is low.
- Reset mid-operation aborts the operation without producing output. The first post-reset cycle is IDLE with in_ready = 1.
- Input handshake fires in cycle T (in_valid & in_ready):
  - SKIP_ZERO = 0: CALC in T+1..T+4, out_valid first high in T+5.
  - SKIP_ZERO = 1: CALC lasts 1–4 cycles, so out_valid appears in T+2 … T+5.
- Output handshake fires in cycle D (out_valid & out_ready). IDLE follows in D+1, and a new operand can be accepted in D+1.
- Minimum initiation interval with out_ready held high: 6 cycles (SKIP_ZERO = 0).
- No combinational path from in_valid/out_ready to out_valid/out_p.
- in_ready depends only on state.

## Test plan
- in_a = 255, in_b = −128 (0x80), SKIP_ZERO = 0 → out_p = 0x8080 (−32640), out_valid in T+5.
- in_a = 200, in_b = 100 → out_p = 0x4E20 (20000). in_a = 0, in_b = 0x55 → out_p = 0.
- SKIP_ZERO = 1:
  - in_a = 5, in_b = 0xFF → 1 CALC cycle, out_valid in T+2, out_p = 0xFFFB.
  - in_b = 1 → out_p = 5 in T+2.
  - in_b = 0x40 → 4 CALC cycles, out_p = 320.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE with in_valid = 1 → out_p stable, in_ready = 0, no new operand latched. On release, the next operand is accepted in D+1.
- Reset mid-CALC: assert rst_n = 0 for one edge during the 2nd CALC cycle → out_valid stays 0, state IDLE. A following 17 × −3 returns 0xFFCD (−51).
- Random sweep, 10k pairs, both SKIP_ZERO values, random out_ready → every out_p equals in_a × in_b as signed 16-bit, in order.

Source files
------------

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: unsigned 8-bit activation x signed 8-bit weight,
// one Booth digit per cycle through a single time-shared boothEncoding slice.

module boothEncoding (
    input  logic [8:0] a,
    input  logic [2:0] encoding,
    output logic [9:0] pp
);
    always_comb begin
        pp = '0;
        unique case (encoding)
            3'b001, 3'b010: pp = {1'b0, a};
            3'b011:         pp = {a, 1'b0};
            3'b100:         pp = -{a, 1'b0};
            3'b101, 3'b110: pp = -{1'b0, a};
            default:        pp = '0;
        endcase
    end
endmodule

module booth_seq_mult #(
    parameter int unsigned SKIP_ZERO = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  a_reg, b_reg;
    logic [15:0] acc;
    logic [1:0]  idx;

    logic [8:0]  b_ext;
    logic [2:0]  digit;
    logic [9:0]  pp;
    logic [15:0] addend;
    logic [7:0]  rest;
    logic        skip_hit;

    // b_ext carries the implicit b[-1] = 0 below bit 0
    assign b_ext  = {b_reg, 1'b0};
    assign digit  = b_ext[{idx, 1'b0} +: 3];
    assign addend = {{6{pp[9]}}, pp} << {idx, 1'b0};

    // Remaining digits are all zero iff b_reg[7:2*idx+1] is all-equal, i.e. the
    // arithmetic shift leaves only sign copies.
    assign rest     = 8'($signed(b_reg) >>> {idx, 1'b1});
    assign skip_hit = (SKIP_ZERO != 0) && ((rest == '0) || (rest == '1));

    boothEncoding u_enc (
        .a        ({1'b0, a_reg}),
        .encoding (digit),
        .pp       (pp)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    if (idx == 2'd3 || skip_hit) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            idx   <= '0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    a_reg <= in_a;
                    b_reg <= in_b;
                    acc   <= '0;
                    idx   <= '0;
                end
                CALC: begin
                    acc <= acc + addend;
                    idx <= idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_p     = acc;
endmodule
